// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: segment masks,
// the segment vector type and the decimal/hex glyph tables.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   // One mask per physical segment, active-high
   localparam seg_t SEG_TOP  = 7'b0000001;
   localparam seg_t SEG_UR   = 7'b0000010;
   localparam seg_t SEG_LR   = 7'b0000100;
   localparam seg_t SEG_BOT  = 7'b0001000;
   localparam seg_t SEG_LL   = 7'b0010000;
   localparam seg_t SEG_UL   = 7'b0100000;
   localparam seg_t SEG_MID  = 7'b1000000;
   localparam seg_t SEG_NONE = 7'b0000000;

   // Decimal glyphs; nibbles 10..15 are invalid and stay dark
   localparam seg_t DEC_GLYPH [16] = '{
      SEG_TOP | SEG_UR | SEG_LR | SEG_BOT | SEG_LL | SEG_UL,            // 0
      SEG_UR | SEG_LR,                                                  // 1
      SEG_TOP | SEG_UR | SEG_BOT | SEG_LL | SEG_MID,                    // 2
      SEG_TOP | SEG_UR | SEG_LR | SEG_BOT | SEG_MID,                    // 3
      SEG_UR | SEG_LR | SEG_UL | SEG_MID,                               // 4
      SEG_TOP | SEG_LR | SEG_BOT | SEG_UL | SEG_MID,                    // 5
      SEG_LR | SEG_BOT | SEG_LL | SEG_UL | SEG_MID,                     // 6 (no tail)
      SEG_TOP | SEG_UR | SEG_LR,                                        // 7
      SEG_TOP | SEG_UR | SEG_LR | SEG_BOT | SEG_LL | SEG_UL | SEG_MID,  // 8
      SEG_TOP | SEG_UR | SEG_LR | SEG_UL | SEG_MID,                     // 9 (no tail)
      SEG_NONE, SEG_NONE, SEG_NONE, SEG_NONE, SEG_NONE, SEG_NONE
   };

   // Hex glyphs; 6 and 9 gain their tails so they cannot be confused with b and q
   localparam seg_t HEX_GLYPH [16] = '{
      SEG_TOP | SEG_UR | SEG_LR | SEG_BOT | SEG_LL | SEG_UL,            // 0
      SEG_UR | SEG_LR,                                                  // 1
      SEG_TOP | SEG_UR | SEG_BOT | SEG_LL | SEG_MID,                    // 2
      SEG_TOP | SEG_UR | SEG_LR | SEG_BOT | SEG_MID,                    // 3
      SEG_UR | SEG_LR | SEG_UL | SEG_MID,                               // 4
      SEG_TOP | SEG_LR | SEG_BOT | SEG_UL | SEG_MID,                    // 5
      SEG_TOP | SEG_LR | SEG_BOT | SEG_LL | SEG_UL | SEG_MID,           // 6
      SEG_TOP | SEG_UR | SEG_LR,                                        // 7
      SEG_TOP | SEG_UR | SEG_LR | SEG_BOT | SEG_LL | SEG_UL | SEG_MID,  // 8
      SEG_TOP | SEG_UR | SEG_LR | SEG_BOT | SEG_UL | SEG_MID,           // 9
      SEG_TOP | SEG_UR | SEG_LR | SEG_LL | SEG_UL | SEG_MID,            // A
      SEG_LR | SEG_BOT | SEG_LL | SEG_UL | SEG_MID,                     // b
      SEG_TOP | SEG_BOT | SEG_LL | SEG_UL,                              // C
      SEG_UR | SEG_LR | SEG_BOT | SEG_LL | SEG_MID,                     // d
      SEG_TOP | SEG_BOT | SEG_LL | SEG_UL | SEG_MID,                    // E
      SEG_TOP | SEG_LL | SEG_UL | SEG_MID                               // F
   };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder selecting the decimal or hex table.
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output seg_t       glyph
);

   assign glyph = hex_mode ? HEX_GLYPH[nibble] : DEC_GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: scans one digit per slot with
// a dark guard cycle, swaps new display data only at frame boundaries, and
// applies leading-zero blanking and whole-display blink.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    load_i,
   input  logic                    hex_mode_i,
   input  logic                    blank_lz_i,
   input  logic                    blink_i,
   output logic [6:0]              segments_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   digit_en_o,
   output logic                    frame_o
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] disp;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [4*NUM_DIGITS-1:0] pend;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pend_valid;
   logic                    phase_on;
   logic [BF_W-1:0]         frame_cnt;

   logic                    slot_end;
   logic                    frame_end;
   logic                    guard;
   logic                    dark;

   logic [3:0]              sel_nib;
   logic                    sel_dp;
   logic [NUM_DIGITS-1:0]   sel_onehot;
   logic                    sel_zero;
   logic [NUM_DIGITS-1:0]   zero_above;
   logic                    zero_run;
   seg_t                    glyph;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);
   assign guard     = (cnt == '0);
   assign dark      = blink_i && !phase_on;

   // Prescaler and digit index: one slot per SCAN_DIV cycles, digits in ascending order
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Pending/display registers: the display only changes at a frame boundary so a frame never tears
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         disp       <= '0;
         disp_dp    <= '0;
         pend       <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (load_i) begin
            pend    <= value_i;
            pend_dp <= dp_i;
         end
         if (frame_end) begin
            if (load_i) begin
               disp    <= value_i;
               disp_dp <= dp_i;
            end else if (pend_valid) begin
               disp    <= pend;
               disp_dp <= pend_dp;
            end
            pend_valid <= 1'b0;
         end else if (load_i) begin
            pend_valid <= 1'b1;
         end
      end
   end

   // Blink phase free-runs on frame boundaries so enabling blink never restarts its rhythm
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         phase_on  <= 1'b1;
      end else if (frame_end) begin
         if (frame_cnt == BF_LAST) begin
            frame_cnt <= '0;
            phase_on  <= !phase_on;
         end else begin
            frame_cnt <= frame_cnt + BF_W'(1);
         end
      end
   end

   // Select the active digit's nibble, dp and enable, and find digits with only zeros at and above them
   always_comb begin
      sel_nib    = '0;
      sel_dp     = 1'b0;
      sel_onehot = '0;
      sel_zero   = 1'b0;
      zero_above = '0;
      zero_run   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run      = zero_run && (disp[4*i +: 4] == 4'h0);
         zero_above[i] = zero_run;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_nib       = disp[4*i +: 4];
            sel_dp        = disp_dp[i];
            sel_onehot[i] = 1'b1;
            sel_zero      = zero_above[i];
         end
      end
   end

   seg7_glyph u_glyph (
      .nibble   (sel_nib),
      .hex_mode (hex_mode_i),
      .glyph    (glyph)
   );

   // Output registers: guard slot is fully dark, blanking hits segments only, blink hits segments and dp
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         segments_o <= '0;
         dp_o       <= 1'b0;
         digit_en_o <= '0;
         frame_o    <= 1'b0;
      end else begin
         frame_o <= guard && (idx == '0);
         if (guard) begin
            segments_o <= '0;
            dp_o       <= 1'b0;
            digit_en_o <= '0;
         end else begin
            digit_en_o <= sel_onehot;
            dp_o       <= sel_dp && !dark;
            if (dark || (blank_lz_i && (idx != '0) && sel_zero)) begin
               segments_o <= '0;
            end else begin
               segments_o <= glyph;
            end
         end
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

- Parametrised, time-multiplexed driver for a common-segment multi-digit 7-segment display.
- Holds a tear-free display register loaded by a one-cycle strobe. Scans one digit at a time with an anti-ghosting guard cycle.
- Decodes each nibble in decimal or hex mode, with optional leading-zero blanking and whole-display blink.
- Sits between the counter/datapath logic and the chip output pins. It supersedes direct per-digit decoding for multi-digit boards.

## Interface
- NUM_DIGITS, 4: digits driven. Legal range 1..8.
- SCAN_DIV, 1000: clock cycles per digit slot, including the guard cycle. Must be ≥2.
- BLINK_FRAMES, 64: complete frames per blink half-period. Must be ≥1.
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- value_i  in  4*NUM_DIGITS  display nibbles; [3:0] is digit 0, the least significant digit
- dp_i  in  NUM_DIGITS  decimal-point request per digit
- load_i  in  1  one-cycle strobe; captures value_i and dp_i
- hex_mode_i  in  1  1 = hex glyphs, 0 = decimal glyphs
- blank_lz_i  in  1  1 = blank leading zeros
- blink_i  in  1  1 = blink the whole display
- segments_o  out  7  bit0 = top, bit1 = upper-right, bit2 = lower-right, bit3 = bottom, bit4 = lower-left, bit5 = upper-left, bit6 = middle; active-high
- dp_o  out  1  decimal point for the active digit; active-high
- digit_en_o  out  NUM_DIGITS  one-hot digit enable, active-high
- frame_o  out  1  one-cycle pulse marking the start of each frame

## Operation
- **Prescaler and index.** Prescaler cnt runs 0..SCAN_DIV-1. Digit index idx runs 0..NUM_DIGITS-1.
  - When cnt==SCAN_DIV-1: cnt→0 and idx increments, wrapping to 0.
  - The frame boundary is the cycle where cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1.
- **Guard slot.** Slot position cnt==0 is the guard: digit_en_o, segments_o and dp_o are all 0.
- **Active slot.** Positions cnt 1..SCAN_DIV-1 drive:
  - digit_en_o = one-hot(idx);
  - segments_o = glyph of disp nibble idx;
  - dp_o = disp_dp[idx].
- **Loading (tear-free).**
  - On any cycle with load_i=1: pending ← {value_i, dp_i} and pend_valid ← 1.
  - At the frame boundary, if load_i=1 in that same cycle, disp ← value_i/dp_i directly. Otherwise, if pend_valid=1, disp ← pending.
  - pend_valid clears at every frame boundary.
  - Multiple loads within one frame: the last one wins.
- **Decimal glyphs (hex_mode_i=0).**
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111.
  - Nibbles 10..15 display as 0000000.
- **Hex glyphs (hex_mode_i=1).**
  - 0..9 use the decimal glyphs, except 6=1111101 and 9=1101111.
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- **Leading-zero blanking (blank_lz_i=1).**
  - A digit is blanked (segments 0000000) when it and every more-significant digit hold nibble 0.
  - Digit 0 is never blanked.
  - A nonzero nibble stops blanking, including an invalid decimal 10..15.
  - dp_o is not affected by blanking.
- **Blink.**
  - Phase register starts ON at reset.
  - The phase toggles after every BLINK_FRAMES frame boundaries, regardless of blink_i.
  - When blink_i=1 and phase=OFF, segments_o and dp_o are forced to 0. digit_en_o keeps scanning.
- **Mid-operation changes.** hex_mode_i, blank_lz_i and blink_i are sampled live every cycle and are not latched by load_i.
- **Reset.** Assertion at any time returns every register to its reset value and discards the pending load:
  - cnt=0, idx=0, disp=0, disp_dp=0, pend_valid=0, phase=ON;
  - all outputs 0.

## Timing
- All outputs are registered. Each output reflects the internal cnt/idx/disp state of the previous cycle.
- After the first rising edge with rst_n=1, outputs show the guard slot (all 0).
- digit_en_o=…0001 first appears after the second rising edge with rst_n=1.
- Each digit is enabled for SCAN_DIV-1 cycles, followed by 1 guard cycle. A frame is NUM_DIGITS*SCAN_DIV cycles.
- frame_o is high for exactly one cycle, coincident with the guard slot of digit 0.
- A newly loaded value first appears in the frame following the next frame boundary. Worst-case load-to-display latency is NUM_DIGITS*SCAN_DIV+2 cycles.
- Blink half-period is BLINK_FRAMES*NUM_DIGITS*SCAN_DIV cycles.

## Structure
- Package seg7_pkg holds:
  - the segment-bit constants;
  - the 16-entry decimal and hex glyph constant arrays;
  - the typedef for the 7-bit segment vector.
- Sub-module seg7_glyph is a combinational nibble-to-glyph decoder with a hex_mode input. It is instantiated once and fed the nibble selected by idx.
- The top level contains the prescaler, index counter, display/pending registers, blink phase counter, leading-zero logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4 and BLINK_FRAMES=2.
- **Reset and scan.** Release rst_n.
  - Outputs are 0 for 1 cycle.
  - digit_en_o then runs 0001×3, 0000, 0010×3, 0000, 0100×3, 0000, 1000×3, 0000, repeating.
  - frame_o pulses every 16 cycles.
- **Decimal decode.** Load 0x1234, decimal mode.
  - Digit 0 shows 1100110, digit 1 shows 1001111, digit 2 shows 1011011, digit 3 shows 0000110.
  - Nothing changes until after the next frame boundary.
- **Hex and invalid decimal.** Load 0xAF69.
  - In hex mode: digit 0 shows 1101111 and digit 1 shows 1111101.
  - In decimal mode: digits 3 and 2 show 0000000, digit 1 shows 1111100 and digit 0 shows 1100111.
- **Leading-zero blanking.** blank_lz_i=1.
  - With 0x0050: digits 3 and 2 are blank, digit 1 shows 1101101, digit 0 shows 0111111.
  - With 0x0000: only digit 0 is lit, showing 0111111.
- **Load collisions.**
  - Loads of 0x1111 mid-frame, then 0x2222 in the same frame: 0x2222 is displayed.
  - A load of 0x3333 in the exact frame-boundary cycle is displayed from the next frame.
- **Blink and reset mid-frame.**
  - blink_i=1: segments are lit for 2 frames, forced 0 for 2 frames, and digit_en_o keeps scanning throughout.
  - Asserting rst_n low mid-slot gives all outputs 0 on the next edge, and a pending load is lost.
